// File: rtl/alu_op_sequencer.sv
// Sequencer for the 8-bit ALU instruction group: owns A and F, gathers the second
// operand (register, (HL) or d8), drives the external ALU stage for one cycle and
// pads the instruction out to LR35902 M-cycle timing.
module alu_op_sequencer #(
   parameter int unsigned T_PER_M = 4,
   parameter logic [7:0]  A_RESET = 8'h01,
   parameter logic [7:0]  F_RESET = 8'hB0
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Start,
   input  logic [7:0] i_Opcode,
   output logic       o_Busy,
   output logic       o_Done,
   output logic       o_Illegal,
   output logic [2:0] o_RegSel,
   input  logic [7:0] i_RegData,
   output logic       o_ByteReq,
   output logic       o_ByteSrc,
   input  logic       i_ByteValid,
   input  logic [7:0] i_ByteData,
   output logic [7:0] o_AluA,
   output logic [7:0] o_AluB,
   output logic [2:0] o_AluOp,
   output logic [3:0] o_AluF,
   input  logic [7:0] i_AluResult,
   input  logic [3:0] i_AluFlags,
   input  logic       i_LoadA,
   input  logic       i_LoadF,
   input  logic [7:0] i_LoadData,
   output logic [7:0] o_A,
   output logic [7:0] o_F
);

   // 5 bits covers 2*T_PER_M for T_PER_M up to 15; the count saturates on long fetches.
   localparam int unsigned      CntW    = 5;
   localparam logic [CntW-1:0]  CntMax  = '1;
   localparam logic [CntW-1:0]  MinReg  = CntW'(T_PER_M);
   localparam logic [CntW-1:0]  MinByte = CntW'(2 * T_PER_M);

   typedef enum logic [1:0] {StIdle, StFetch, StExec, StHold} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d, cnt_inc, min_cnt;
   logic [7:0]      a_q, a_d, f_q, f_d, opnd_q, opnd_d;
   logic [2:0]      op_q, op_d;
   logic            is_byte_q, is_byte_d;
   logic            byte_src_q, byte_src_d;
   logic            illegal_q, illegal_d;
   logic            legal, needs_byte, done, in_exec;

   // Decode the incoming opcode: ALU group membership and whether a byte fetch is needed.
   always_comb begin
      legal      = (i_Opcode[7:6] == 2'b10) ||
                   ((i_Opcode[7:6] == 2'b11) && (i_Opcode[2:0] == 3'b110));
      needs_byte = (i_Opcode[7:6] == 2'b11) || (i_Opcode[2:0] == 3'b110);
   end

   assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
   assign min_cnt = is_byte_q ? MinByte : MinReg;
   // A late fetch can push the count past the minimum, hence >= rather than ==.
   assign done    = (state_q == StHold) && (cnt_q >= min_cnt);
   assign in_exec = (state_q == StExec);

   // Next-state, operand capture and A/F write-back.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      f_d        = f_q;
      opnd_d     = opnd_q;
      op_d       = op_q;
      is_byte_d  = is_byte_q;
      byte_src_d = byte_src_q;
      illegal_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (i_Start) begin
               // Start wins over any simultaneous load.
               if (legal) begin
                  op_d      = i_Opcode[5:3];
                  cnt_d     = '0;
                  is_byte_d = needs_byte;
                  if (needs_byte) begin
                     byte_src_d = ~i_Opcode[6];
                     state_d    = StFetch;
                  end else begin
                     opnd_d  = (i_Opcode[2:0] == 3'b111) ? a_q : i_RegData;
                     state_d = StExec;
                  end
               end else begin
                  illegal_d = 1'b1;
               end
            end else begin
               if (i_LoadA) a_d = i_LoadData;
               if (i_LoadF) f_d = {i_LoadData[7:4], 4'h0};
            end
         end
         StFetch: begin
            cnt_d = cnt_inc;
            if (i_ByteValid) begin
               opnd_d  = i_ByteData;
               state_d = StExec;
            end
         end
         StExec: begin
            cnt_d   = cnt_inc;
            a_d     = i_AluResult;
            f_d     = {i_AluFlags, 4'h0};
            state_d = StHold;
         end
         StHold: begin
            if (done) begin
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         a_q        <= A_RESET;
         f_q        <= {F_RESET[7:4], 4'h0};
         opnd_q     <= '0;
         op_q       <= '0;
         is_byte_q  <= 1'b0;
         byte_src_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         f_q        <= f_d;
         opnd_q     <= opnd_d;
         op_q       <= op_d;
         is_byte_q  <= is_byte_d;
         byte_src_q <= byte_src_d;
         illegal_q  <= illegal_d;
      end
   end

   // Outputs; the ALU ports are only live during the single EXEC cycle.
   always_comb begin
      o_Busy    = (state_q != StIdle);
      o_Done    = done;
      o_Illegal = illegal_q;
      o_RegSel  = i_Opcode[2:0];
      o_ByteReq = (state_q == StFetch);
      o_ByteSrc = byte_src_q;
      o_AluA    = in_exec ? a_q : 8'h00;
      o_AluB    = in_exec ? opnd_q : 8'h00;
      o_AluOp   = in_exec ? op_q : 3'b000;
      o_AluF    = in_exec ? f_q[7:4] : 4'h0;
      o_A       = a_q;
      o_F       = f_q;
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a vector table of ALU instructions with
// hand-computed results and latencies, plus sequences for illegal opcodes,
// start/load priority, start-while-busy and reset during a fetch.
module tb_alu_op_sequencer;

   logic       i_Clk, i_Reset, i_Start;
   logic [7:0] i_Opcode;
   logic       o_Busy, o_Done, o_Illegal;
   logic [2:0] o_RegSel;
   logic [7:0] i_RegData;
   logic       o_ByteReq, o_ByteSrc, i_ByteValid;
   logic [7:0] i_ByteData;
   logic [7:0] o_AluA, o_AluB;
   logic [2:0] o_AluOp;
   logic [3:0] o_AluF;
   logic [7:0] i_AluResult;
   logic [3:0] i_AluFlags;
   logic       i_LoadA, i_LoadF;
   logic [7:0] i_LoadData;
   logic [7:0] o_A, o_F;

   int checks = 0;
   int errors = 0;

   alu_op_sequencer #(
      .T_PER_M (4),
      .A_RESET (8'h01),
      .F_RESET (8'hB0)
   ) dut (
      .i_Clk       (i_Clk),
      .i_Reset     (i_Reset),
      .i_Start     (i_Start),
      .i_Opcode    (i_Opcode),
      .o_Busy      (o_Busy),
      .o_Done      (o_Done),
      .o_Illegal   (o_Illegal),
      .o_RegSel    (o_RegSel),
      .i_RegData   (i_RegData),
      .o_ByteReq   (o_ByteReq),
      .o_ByteSrc   (o_ByteSrc),
      .i_ByteValid (i_ByteValid),
      .i_ByteData  (i_ByteData),
      .o_AluA      (o_AluA),
      .o_AluB      (o_AluB),
      .o_AluOp     (o_AluOp),
      .o_AluF      (o_AluF),
      .i_AluResult (i_AluResult),
      .i_AluFlags  (i_AluFlags),
      .i_LoadA     (i_LoadA),
      .i_LoadF     (i_LoadF),
      .i_LoadData  (i_LoadData),
      .o_A         (o_A),
      .o_F         (o_F)
   );

   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   // Combinational ALU stage the sequencer drives (flags {Z,N,H,C}).
   logic [8:0] alu_sum;
   logic [4:0] alu_half;
   logic       alu_cin;
   always_comb begin
      alu_sum     = '0;
      alu_half    = '0;
      alu_cin     = 1'b0;
      i_AluResult = o_AluA;
      i_AluFlags  = 4'h0;
      case (o_AluOp)
         3'd0, 3'd1: begin
            alu_cin     = (o_AluOp == 3'd1) & o_AluF[0];
            alu_sum     = {1'b0, o_AluA} + {1'b0, o_AluB} + {8'h00, alu_cin};
            alu_half    = {1'b0, o_AluA[3:0]} + {1'b0, o_AluB[3:0]} + {4'h0, alu_cin};
            i_AluResult = alu_sum[7:0];
            i_AluFlags  = {alu_sum[7:0] == 8'h00, 1'b0, alu_half[4], alu_sum[8]};
         end
         3'd2, 3'd3, 3'd7: begin
            alu_cin     = (o_AluOp == 3'd3) & o_AluF[0];
            alu_sum     = {1'b0, o_AluA} - {1'b0, o_AluB} - {8'h00, alu_cin};
            alu_half    = {1'b0, o_AluA[3:0]} - {1'b0, o_AluB[3:0]} - {4'h0, alu_cin};
            i_AluResult = (o_AluOp == 3'd7) ? o_AluA : alu_sum[7:0];
            i_AluFlags  = {alu_sum[7:0] == 8'h00, 1'b1, alu_half[4], alu_sum[8]};
         end
         3'd4: begin
            i_AluResult = o_AluA & o_AluB;
            i_AluFlags  = {(o_AluA & o_AluB) == 8'h00, 1'b0, 1'b1, 1'b0};
         end
         3'd5: begin
            i_AluResult = o_AluA ^ o_AluB;
            i_AluFlags  = {(o_AluA ^ o_AluB) == 8'h00, 3'b000};
         end
         default: begin
            i_AluResult = o_AluA | o_AluB;
            i_AluFlags  = {(o_AluA | o_AluB) == 8'h00, 3'b000};
         end
      endcase
   end

   typedef struct {
      logic [7:0] opcode;
      logic [7:0] a_init;
      logic [7:0] f_init;
      logic [7:0] reg_data;
      logic [7:0] byte_data;
      int         byte_delay;  // -1: register source
      logic       exp_src;
      logic [7:0] exp_a;
      logic [7:0] exp_f;
      int         exp_lat;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic load_af(input logic [7:0] a, input logic [7:0] f);
      @(negedge i_Clk);
      i_LoadA    = 1'b1;
      i_LoadData = a;
      @(negedge i_Clk);
      i_LoadA    = 1'b0;
      i_LoadF    = 1'b1;
      i_LoadData = f;
      @(negedge i_Clk);
      i_LoadF    = 1'b0;
   endtask

   // Issue one opcode; returns at the negedge of cycle 0 (first cycle after accept).
   task automatic start_op(input logic [7:0] op, input logic [7:0] rd);
      @(negedge i_Clk);
      i_Start   = 1'b1;
      i_Opcode  = op;
      i_RegData = rd;
      @(negedge i_Clk);
      i_Start   = 1'b0;
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      int   done_cyc;
      logic req_seen, src_err;
      v = vecs[idx];
      load_af(v.a_init, v.f_init);
      start_op(v.opcode, v.reg_data);
      done_cyc = -1;
      req_seen = 1'b0;
      src_err  = 1'b0;
      for (int c = 0; c < 64; c++) begin
         if (o_Done) begin
            done_cyc = c;
            break;
         end
         if (o_ByteReq) begin
            req_seen = 1'b1;
            if (o_ByteSrc !== v.exp_src) src_err = 1'b1;
         end
         i_ByteValid = (v.byte_delay >= 0) && (c == v.byte_delay);
         i_ByteData  = v.byte_data;
         @(negedge i_Clk);
      end
      i_ByteValid = 1'b0;
      check($sformatf("vec%0d latency", idx), done_cyc, v.exp_lat);
      check($sformatf("vec%0d busy at done", idx), o_Busy, 1'b1);
      check($sformatf("vec%0d A", idx), o_A, v.exp_a);
      check($sformatf("vec%0d F", idx), o_F, v.exp_f);
      check($sformatf("vec%0d byte req seen", idx), req_seen, v.byte_delay >= 0);
      check($sformatf("vec%0d byte src", idx), src_err, 1'b0);
      @(negedge i_Clk);
      check($sformatf("vec%0d busy after done", idx), o_Busy, 1'b0);
      check($sformatf("vec%0d done pulse width", idx), o_Done, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int done_seen;
      //              opcode a_in   f_in   reg    byte   dly src exp_a  exp_f  lat
      vecs[0] = '{8'h80, 8'h3A, 8'h00, 8'hC6, 8'h00, -1, 1'b0, 8'h00, 8'hB0, 4};  // ADD A,B
      vecs[1] = '{8'h8F, 8'h80, 8'h10, 8'h55, 8'h00, -1, 1'b0, 8'h01, 8'h10, 4};  // ADC A,A
      vecs[2] = '{8'hD6, 8'h3E, 8'h00, 8'h00, 8'h3E,  2, 1'b0, 8'h00, 8'hC0, 8};  // SUB d8
      vecs[3] = '{8'hBE, 8'h3C, 8'h00, 8'h00, 8'h40, 12, 1'b1, 8'h3C, 8'h50, 14}; // CP (HL) late
      vecs[4] = '{8'hE6, 8'hF0, 8'h00, 8'h00, 8'h0F,  0, 1'b0, 8'h00, 8'hA0, 8};  // AND d8
      vecs[5] = '{8'hA9, 8'hFF, 8'hF0, 8'h0F, 8'h00, -1, 1'b0, 8'hF0, 8'h00, 4};  // XOR C
      vecs[6] = '{8'hB6, 8'h12, 8'h00, 8'h00, 8'h21,  6, 1'b1, 8'h33, 8'h00, 8};  // OR (HL) on MIN
      vecs[7] = '{8'h9E, 8'h10, 8'h10, 8'h00, 8'h0F,  7, 1'b1, 8'h00, 8'hE0, 9};  // SBC (HL) past MIN

      i_Reset = 1'b1; i_Start = 1'b0; i_Opcode = 8'h00; i_RegData = 8'h00;
      i_ByteValid = 1'b0; i_ByteData = 8'h00;
      i_LoadA = 1'b0; i_LoadF = 1'b0; i_LoadData = 8'h00;
      repeat (3) @(negedge i_Clk);
      i_Reset = 1'b0;
      @(negedge i_Clk);
      check("reset A", o_A, 8'h01);
      check("reset F", o_F, 8'hB0);
      check("reset busy", o_Busy, 1'b0);
      check("reset byte req", o_ByteReq, 1'b0);
      check("reset done", o_Done, 1'b0);
      check("reset alu ports", {o_AluA, o_AluB, o_AluOp, o_AluF}, 23'h0);

      for (int i = 0; i < 8; i++) run_vec(i);

      // Illegal opcode: pulse, no state change; F low nibble forced to 0 by the load.
      load_af(8'h5A, 8'h3F);
      check("load F low bits", o_F, 8'h30);
      start_op(8'h40, 8'h00);
      check("illegal pulse", o_Illegal, 1'b1);
      check("illegal not busy", o_Busy, 1'b0);
      @(negedge i_Clk);
      check("illegal pulse width", o_Illegal, 1'b0);
      check("illegal A kept", o_A, 8'h5A);
      check("illegal F kept", o_F, 8'h30);

      // Start wins over a simultaneous load; start and loads while busy are ignored.
      load_af(8'h10, 8'h00);
      @(negedge i_Clk);
      i_Start = 1'b1; i_Opcode = 8'h80; i_RegData = 8'h01;
      i_LoadA = 1'b1; i_LoadData = 8'h77;
      @(negedge i_Clk);
      i_Start = 1'b0; i_LoadA = 1'b0;
      @(negedge i_Clk);  // cycle 1
      i_Start = 1'b1; i_Opcode = 8'h40; i_LoadA = 1'b1; i_LoadF = 1'b1; i_LoadData = 8'h99;
      @(negedge i_Clk);  // cycle 2
      i_Start = 1'b0; i_LoadA = 1'b0; i_LoadF = 1'b0;
      check("busy start no illegal", o_Illegal, 1'b0);
      check("busy still", o_Busy, 1'b1);
      repeat (2) @(negedge i_Clk);  // cycle 4
      check("priority done at 4", o_Done, 1'b1);
      check("priority A", o_A, 8'h11);
      check("priority F", o_F, 8'h00);
      @(negedge i_Clk);

      // Reset while waiting for the operand byte.
      load_af(8'h22, 8'h00);
      start_op(8'hC6, 8'h00);
      check("fetch req", o_ByteReq, 1'b1);
      check("fetch src d8", o_ByteSrc, 1'b0);
      @(negedge i_Clk);
      i_Reset = 1'b1;
      @(negedge i_Clk);
      i_Reset = 1'b0;
      check("reset mid req", o_ByteReq, 1'b0);
      check("reset mid A", o_A, 8'h01);
      check("reset mid F", o_F, 8'hB0);
      check("reset mid busy", o_Busy, 1'b0);
      done_seen = 0;
      for (int c = 0; c < 12; c++) begin
         if (o_Done) done_seen++;
         @(negedge i_Clk);
      end
      check("reset mid no done", done_seen, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
